// File: rtl/lcd_ctrl_if.sv
// LSU-side register interface of the HD44780 LCD controller.
//   lcd_wr   : one-cycle strobe, the LSU stored to the LCD register this cycle
//   lcd_word : stored word, [31]=ON, [30]=clear-overflow, [9]=RS, [7:0]=DATA
//   status   : {ON, 27'b0, overflow, pending, busy, 1'b0}, fed to the LSU load mux
// master = LSU, slave = controller.
interface lcd_ctrl_if;
  logic        lcd_wr;
  logic [31:0] lcd_word;
  logic [31:0] status;

  modport master (output lcd_wr, output lcd_word, input status);
  modport slave  (input lcd_wr, input lcd_word, output status);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 character LCD write controller.
// Each stored word becomes one timed write cycle: setup, EN pulse, hold, then an execution
// wait whose length depends on whether the command is a slow clear/home. A one-entry buffer
// absorbs a store that arrives while a write is in progress; further stores are dropped and
// flagged by a sticky overflow bit that software clears with a control-only write ([30]=1).
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   lsu_io         : LSU register interface (strobe, word, status readback)
//   o_lcd_data     : DB[7:0]
//   o_lcd_rs       : register select
//   o_lcd_rw       : tied 0, write-only
//   o_lcd_en       : enable strobe
//   o_lcd_on       : power/backlight
module lcd_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  lcd_ctrl_if.slave        lsu_io,
  output logic [7:0]       o_lcd_data,
  output logic             o_lcd_rs,
  output logic             o_lcd_rw,
  output logic             o_lcd_en,
  output logic             o_lcd_on
);

  localparam int unsigned CntW = (T_CLEAR > 1) ? $clog2(T_CLEAR) : 1;

  localparam logic [CntW-1:0] SetupLd = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] EnLd    = CntW'(T_EN - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(T_HOLD - 1);
  localparam logic [CntW-1:0] ExecLd  = CntW'(T_EXEC - 1);
  localparam logic [CntW-1:0] ClearLd = CntW'(T_CLEAR - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      data_q;
  logic            rs_q;
  logic            en_q;
  logic            on_q;
  logic            clr_q;       // issued word is clear/home, needs the long wait
  logic            pend_q;
  logic            pend_rs_q;
  logic [7:0]      pend_data_q;
  logic            ovf_q;

  logic            ctrl_wr;
  logic            data_wr;
  logic            idle;
  logic            issue_buf;
  logic            issue_dir;
  logic            buf_wr;
  logic            drop;
  logic            iss_rs;
  logic [7:0]      iss_data;
  logic            unused_word;

  assign unused_word = ^{lsu_io.lcd_word[29:10], lsu_io.lcd_word[8]};

  always_comb begin
    ctrl_wr   = lsu_io.lcd_wr & lsu_io.lcd_word[30];
    data_wr   = lsu_io.lcd_wr & ~lsu_io.lcd_word[30];
    idle      = (state_q == StIdle);
    // The buffered word always goes first; a store in that same cycle refills the slot.
    issue_buf = idle & pend_q;
    issue_dir = idle & ~pend_q & data_wr;
    buf_wr    = data_wr & ((~idle & ~pend_q) | issue_buf);
    drop      = data_wr & ~idle & pend_q;
    iss_rs    = pend_q ? pend_rs_q   : lsu_io.lcd_word[9];
    iss_data  = pend_q ? pend_data_q : lsu_io.lcd_word[7:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      data_q      <= '0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
      clr_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      // Register-side bookkeeping: ON bit, pending slot, sticky overflow.
      if (issue_dir || buf_wr) begin
        on_q <= lsu_io.lcd_word[31];
      end
      if (buf_wr) begin
        pend_q      <= 1'b1;
        pend_rs_q   <= lsu_io.lcd_word[9];
        pend_data_q <= lsu_io.lcd_word[7:0];
      end else if (issue_buf) begin
        pend_q <= 1'b0;
      end
      if (ctrl_wr) begin
        ovf_q <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
      end

      // Bus timing FSM, one shared down-counter.
      unique case (state_q)
        StIdle: begin
          if (issue_buf || issue_dir) begin
            rs_q    <= iss_rs;
            data_q  <= iss_data;
            clr_q   <= ~iss_rs & (iss_data[7:2] == 6'd0);
            cnt_q   <= SetupLd;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            cnt_q   <= EnLd;
            en_q    <= 1'b1;
            state_q <= StPulse;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            cnt_q   <= HoldLd;
            en_q    <= 1'b0;
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            cnt_q   <= clr_q ? ClearLd : ExecLd;
            state_q <= StWait;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          en_q    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_lcd_data    = data_q;
  assign o_lcd_rs      = rs_q;
  assign o_lcd_rw      = 1'b0;
  assign o_lcd_en      = en_q;
  assign o_lcd_on      = on_q;
  assign lsu_io.status = {on_q, 27'b0, ovf_q, pend_q, ~idle, 1'b0};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters.
module tb_lcd_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;

  int n_chk = 0;
  int n_err = 0;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .T_SETUP (2),
    .T_EN    (4),
    .T_HOLD  (2),
    .T_EXEC  (10),
    .T_CLEAR (30)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .lsu_io     (bus),
    .o_lcd_data (lcd_data),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_lcd_on   (lcd_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // EN pulse monitor: counts rising edges and records DATA at each one.
  int         pulses = 0;
  logic       en_prev = 1'b0;
  logic [7:0] rise_q[$];
  always @(posedge clk) begin
    if (lcd_en && !en_prev) begin
      pulses <= pulses + 1;
      rise_q.push_back(lcd_data);
    end
    en_prev <= lcd_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] w);
    bus.lcd_wr   = 1'b1;
    bus.lcd_word = w;
    tick();
    bus.lcd_wr   = 1'b0;
    bus.lcd_word = '0;
  endtask

  // Samples from the current point until busy drops; reports busy length and EN window.
  task automatic run_txn(output int busy_c, output int en_first, output int en_len);
    busy_c   = 0;
    en_first = -1;
    en_len   = 0;
    while (bus.status[1] && busy_c < 200) begin
      if (lcd_en) begin
        if (en_first < 0) en_first = busy_c;
        en_len++;
      end
      busy_c++;
      tick();
    end
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (bus.status[1] && c < 200) begin
      c++;
      tick();
    end
  endtask

  initial begin
    int b, ef, el, base;
    rst          = 1'b1;
    bus.lcd_wr   = 1'b0;
    bus.lcd_word = '0;
    tick();
    tick();
    chk("rst_status", bus.status, 32'h0);
    chk("rst_pins", {lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on}, 12'h0);
    rst = 1'b0;
    tick();

    // Data write 'A' with ON.
    base = pulses;
    strobe(32'h8000_0241);
    chk("a_rs_data", {lcd_rs, lcd_data}, {1'b1, 8'h41});
    chk("a_status", bus.status, 32'h8000_0002);
    chk("a_on_rw", {lcd_on, lcd_rw}, 2'b10);
    run_txn(b, ef, el);
    chk("a_busy", b, 18);
    chk("a_en_first", ef, 2);
    chk("a_en_len", el, 4);
    chk("a_pulses", pulses - base, 1);
    chk("a_idle_status", bus.status, 32'h8000_0000);

    // Clear takes the long wait; home too; RS=1 with 0x01 and 0x38 do not.
    strobe(32'h0000_0001);
    chk("clr_data", {lcd_rs, lcd_data, lcd_on}, {1'b0, 8'h01, 1'b0});
    run_txn(b, ef, el);
    chk("clr_busy", b, 38);
    strobe(32'h0000_0002);
    run_txn(b, ef, el);
    chk("home_busy", b, 38);
    strobe(32'h0000_0038);
    run_txn(b, ef, el);
    chk("fn_busy", b, 18);
    strobe(32'h0000_0201);
    run_txn(b, ef, el);
    chk("rs1_01_busy", b, 18);

    // Three back-to-back strobes: issue, buffer, drop.
    base = pulses;
    bus.lcd_wr   = 1'b1;
    bus.lcd_word = 32'h8000_0231;
    tick();
    bus.lcd_word = 32'h8000_0232;
    tick();
    chk("c_pend", bus.status, 32'h8000_0006);
    bus.lcd_word = 32'h8000_0233;
    tick();
    bus.lcd_wr   = 1'b0;
    bus.lcd_word = '0;
    chk("c_ovf", bus.status, 32'h8000_000E);
    chk("c_data1", lcd_data, 8'h31);
    wait_idle(b);
    chk("c_rem_busy", b, 16);
    chk("c_idle_pend", bus.status, 32'h8000_000C);
    tick();
    chk("c_data2", {lcd_rs, lcd_data}, {1'b1, 8'h32});
    chk("c_status2", bus.status, 32'h8000_000A);
    run_txn(b, ef, el);
    chk("c_busy2", b, 18);
    chk("c_pulses", pulses - base, 2);
    chk("c_order0", rise_q[base], 8'h31);
    chk("c_order1", rise_q[base + 1], 8'h32);

    // Control-only write clears overflow and starts nothing.
    base = pulses;
    strobe(32'h4000_0000);
    chk("d_status", bus.status[3:0], 4'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("d_idle", bus.status[3:0], 4'h0);
    chk("d_pulses", pulses - base, 0);

    // Strobe in the cycle the buffered word issues refills without overflow.
    base = pulses;
    bus.lcd_wr   = 1'b1;
    bus.lcd_word = 32'h8000_0251;
    tick();
    bus.lcd_word = 32'h8000_0252;
    tick();
    bus.lcd_wr   = 1'b0;
    bus.lcd_word = '0;
    wait_idle(b);
    chk("e_idle_pend", bus.status, 32'h8000_0004);
    strobe(32'h8000_0253);
    chk("e_refill", bus.status, 32'h8000_0006);
    chk("e_data2", lcd_data, 8'h52);
    run_txn(b, ef, el);
    chk("e_busy2", b, 18);
    chk("e_idle_pend2", bus.status, 32'h8000_0004);
    tick();
    chk("e_data3", lcd_data, 8'h53);
    run_txn(b, ef, el);
    chk("e_busy3", b, 18);
    chk("e_final", bus.status, 32'h8000_0000);
    chk("e_pulses", pulses - base, 3);
    chk("e_order0", rise_q[base], 8'h51);
    chk("e_order1", rise_q[base + 1], 8'h52);
    chk("e_order2", rise_q[base + 2], 8'h53);

    // Asynchronous reset in the middle of the EN pulse.
    strobe(32'h8000_0241);
    tick();
    tick();
    chk("f_en_before", lcd_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("f_en_cut", lcd_en, 1'b0);
    chk("f_pins", {lcd_data, lcd_rs, lcd_rw, lcd_on}, 11'h0);
    chk("f_status", bus.status, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    strobe(32'h0000_0248);
    chk("f_rs_data", {lcd_rs, lcd_data}, {1'b1, 8'h48});
    run_txn(b, ef, el);
    chk("f_busy", b, 18);
    chk("f_en_first", ef, 2);
    chk("f_en_len", el, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
